// File: rtl/ahb_lite_bus_ctrl.sv
// ============================================================================
// Module   : ahb_lite_bus_ctrl
// Purpose  : AHB-Lite decoder + response mux for three slaves plus an
//            internal default slave for unmapped addresses.
// Options  : AHB_DEFAULT_SLAVE_ERR_EN - default slave answers active
//            unmapped transfers with a two-cycle ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_bus_ctrl #(
    parameter logic [15:0] S0_BASE = 16'h0000,
    parameter logic [15:0] S1_BASE = 16'h4000,
    parameter logic [15:0] S2_BASE = 16'h4001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL0,
    output logic        HSEL1,
    output logic        HSEL2,
    input  logic        HREADYOUT0,
    input  logic        HREADYOUT1,
    input  logic        HREADYOUT2,
    input  logic        HRESP0,
    input  logic        HRESP1,
    input  logic        HRESP2,
    input  logic [31:0] HRDATA0,
    input  logic [31:0] HRDATA1,
    input  logic [31:0] HRDATA2,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [1:0] c_sel_s0  = 2'd0;
    localparam logic [1:0] c_sel_s1  = 2'd1;
    localparam logic [1:0] c_sel_s2  = 2'd2;
    localparam logic [1:0] c_sel_def = 2'd3;

    logic       w_hit0;
    logic       w_hit1;
    logic       w_hit2;
    logic       w_unmapped;
    logic [1:0] w_asel;
    logic [1:0] r_dsel;
    logic       w_hready;
    logic       w_def_ready;
    logic       w_def_resp;
    logic       w_unused;

    // Priority masking keeps the selects one-hot even if bases are aliased.
    assign w_hit0     = (HADDR[31:16] == S0_BASE);
    assign w_hit1     = (HADDR[31:16] == S1_BASE) & ~w_hit0;
    assign w_hit2     = (HADDR[31:16] == S2_BASE) & ~w_hit0 & ~w_hit1;
    assign w_unmapped = ~(w_hit0 | w_hit1 | w_hit2);

    assign HSEL0 = w_hit0;
    assign HSEL1 = w_hit1;
    assign HSEL2 = w_hit2;

    always_comb begin
        w_asel = c_sel_def;
        if (w_hit0)      w_asel = c_sel_s0;
        else if (w_hit1) w_asel = c_sel_s1;
        else if (w_hit2) w_asel = c_sel_s2;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)      r_dsel <= c_sel_def;
        else if (w_hready) r_dsel <= w_asel;
    end

`ifdef AHB_DEFAULT_SLAVE_ERR_EN
    localparam logic [1:0] c_st_okay = 2'd0;
    localparam logic [1:0] c_st_err1 = 2'd1;
    localparam logic [1:0] c_st_err2 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_err_req;

    assign w_err_req = w_hready & w_unmapped & HTRANS[1];
    assign w_unused  = ^{HADDR[15:0], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= c_st_okay;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_okay: if (w_err_req) w_state_nxt = c_st_err1;
            c_st_err1: w_state_nxt = c_st_err2;
            c_st_err2: w_state_nxt = w_err_req ? c_st_err1 : c_st_okay;
            default:   w_state_nxt = c_st_okay;
        endcase
    end

    always_comb begin
        w_def_ready = 1'b1;
        w_def_resp  = 1'b0;
        case (r_state)
            c_st_err1: begin
                w_def_ready = 1'b0;
                w_def_resp  = 1'b1;
            end
            c_st_err2: begin
                w_def_ready = 1'b1;
                w_def_resp  = 1'b1;
            end
            default: begin
                w_def_ready = 1'b1;
                w_def_resp  = 1'b0;
            end
        endcase
    end
`else
    // Without the error option every unmapped transfer completes as OKAY.
    assign w_def_ready = 1'b1;
    assign w_def_resp  = 1'b0;
    assign w_unused    = ^{HADDR[15:0], HTRANS};
`endif

    always_comb begin
        w_hready = w_def_ready;
        HRESP    = w_def_resp;
        HRDATA   = 32'h0;
        case (r_dsel)
            c_sel_s0: begin
                w_hready = HREADYOUT0;
                HRESP    = HRESP0;
                HRDATA   = HRDATA0;
            end
            c_sel_s1: begin
                w_hready = HREADYOUT1;
                HRESP    = HRESP1;
                HRDATA   = HRDATA1;
            end
            c_sel_s2: begin
                w_hready = HREADYOUT2;
                HRESP    = HRESP2;
                HRDATA   = HRDATA2;
            end
            default: begin
                w_hready = w_def_ready;
                HRESP    = w_def_resp;
                HRDATA   = 32'h0;
            end
        endcase
    end

    assign HREADY = w_hready;

endmodule

`default_nettype wire

// File: doc/ahb_lite_bus_ctrl.md
AHB_LITE_BUS_CTRL -- requirements
Module: ahb_lite_bus_ctrl

Interface
REQ-001 SHALL have parameter S0_BASE, default 16'h0000, HADDR[31:16] match value for slave 0 (RAM).
REQ-002 SHALL have parameter S1_BASE, default 16'h4000, HADDR[31:16] match value for slave 1 (UART).
REQ-003 SHALL have parameter S2_BASE, default 16'h4001, HADDR[31:16] match value for slave 2 (GPIO/LED).
REQ-004 SHALL have port HCLK, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port HADDR, input, 32 bits: master address.
REQ-007 SHALL have port HTRANS, input, 2 bits: master transfer type.
REQ-008 SHALL have ports HSEL0, HSEL1 and HSEL2, output, 1 bit each: slave selects (address phase, combinational).
REQ-009 SHALL have ports HREADYOUT0, HREADYOUT1 and HREADYOUT2, input, 1 bit each: slave ready.
REQ-010 SHALL have ports HRESP0, HRESP1 and HRESP2, input, 1 bit each: slave response.
REQ-011 SHALL have ports HRDATA0, HRDATA1 and HRDATA2, input, 32 bits each: slave read data.
REQ-012 SHALL have port HREADY, output, 1 bit: muxed ready, driven to the master and to every slave HREADY input.
REQ-013 SHALL have port HRESP, output, 1 bit: muxed response to the master.
REQ-014 SHALL have port HRDATA, output, 32 bits: muxed read data to the master.

Function
REQ-015 SHALL assert HSELn combinationally when HADDR[31:16]==Sn_BASE, independent of HTRANS; at most one HSELn high at a time.
REQ-016 SHALL treat an address matching no Sn_BASE as unmapped and route it to the internal default slave.
REQ-017 SHALL register the address-phase selection (S0, S1, S2 or DEF) into a data-phase select register only on HCLK edges where HREADY==1.
REQ-018 SHALL hold the data-phase select register whenever HREADY==0 (wait states), ignoring HADDR/HTRANS changes.
REQ-019 SHALL drive HREADY, HRESP and HRDATA from slave n's HREADYOUTn, HRESPn and HRDATAn when the data-phase select is Sn, with zero added latency.
REQ-020 SHALL implement the default slave FSM with states OKAY, ERR1 and ERR2.
REQ-021 SHALL, in OKAY, drive HREADY=1, HRESP=0 and HRDATA=0 when the data-phase select is DEF.
REQ-022 SHALL transition OKAY->ERR1 on an edge with HREADY==1, unmapped address and HTRANS[1]==1 (NONSEQ/SEQ).
REQ-023 SHALL, in ERR1, drive HREADY=0, HRESP=1, HRDATA=0, then go to ERR2 unconditionally on the next edge.
REQ-024 SHALL, in ERR2, drive HREADY=1, HRESP=1, HRDATA=0, then go to ERR1 if the newly sampled address is unmapped with HTRANS[1]==1, else to OKAY.
REQ-025 SHALL give an unmapped IDLE or BUSY transfer a zero-wait OKAY response (remain in OKAY).
REQ-026 SHALL ignore slave HREADYOUT/HRESP/HRDATA of unselected slaves entirely.
REQ-027 SHALL accept back-to-back transfers to different slaves with no inserted idle cycle; a mapped transfer sampled in ERR2 is routed normally next cycle.

Reset
REQ-028 SHALL, while HRESETn==0, set the data-phase select to DEF and the FSM to OKAY, so that HREADY=1, HRESP=0 and HRDATA=32'h0.
REQ-029 SHALL abandon an in-progress ERR1/ERR2 sequence immediately on reset assertion, with no partial response after release.
REQ-030 SHALL keep HSELn combinational from HADDR during reset.

Configuration
REQ-031 SHALL, when macro AHB_DEFAULT_SLAVE_ERR_EN is defined, implement the two-cycle ERROR response of REQ-022 to REQ-024.
REQ-032 SHALL, when AHB_DEFAULT_SLAVE_ERR_EN is undefined, remove ERR1/ERR2 so that every unmapped transfer gets a zero-wait OKAY with HRDATA=0.

Verification
REQ-033 SHALL verify: NONSEQ read 0x00000010, HRDATA0=32'hDEADBEEF, HREADYOUT0=1 -> HSEL0=1 in the address phase; HRDATA=32'hDEADBEEF and HREADY=1 next cycle.
REQ-034 SHALL verify: NONSEQ write 0x40000000 then NONSEQ read 0x00000004 back-to-back, with HREADYOUT1=0 for 2 cycles -> HREADY low for 2 cycles, the S0 address held unsampled, and the S0 data returned on the cycle after HREADYOUT1 rises.
REQ-035 SHALL verify (macro defined): NONSEQ to 0x20000000 -> data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY; HSEL0..2 all 0 in the address phase.
REQ-036 SHALL verify (macro defined): two consecutive NONSEQ transfers to unmapped 0x80000000, with the second presented during ERR2 -> ERR1, ERR2, ERR1, ERR2 sequence.
REQ-037 SHALL verify: IDLE to 0x20000000 -> HREADY=1, HRESP=0; and, with the macro undefined, NONSEQ to 0x20000000 -> HREADY=1, HRESP=0, HRDATA=0.
REQ-038 SHALL verify: HRESETn pulsed low during ERR1 -> HREADY=1, HRESP=0 and HRDATA=0 immediately, and the first post-reset S1 access routed normally.
